// File: rtl/uflash_arbiter_pkg.sv
// rtl/uflash_arbiter_pkg.sv - shared opcodes and FSM state encoding for the uflash arbiter
package uflash_arbiter_pkg;

    localparam logic [3:0] OP_READ  = 4'b0000;
    localparam logic [3:0] OP_WRITE = 4'b1111;
    localparam logic [3:0] OP_ERASE = 4'b0001;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_LOW  = 2'd2,
        S_WAIT_HIGH = 2'd3
    } state_t;

endpackage

// File: rtl/uflash_rr2.sv
// rtl/uflash_rr2.sv - two-way round-robin picker producing a one-hot grant
module uflash_rr2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_grant
);

    // On contention the port that was not served last wins; otherwise the lone requester wins.
    always_comb begin
        o_grant = i_req;
        if (i_req == 2'b11) begin
            o_grant = i_last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/uflash_arbiter.sv
// rtl/uflash_arbiter.sv - round-robin sharing of one uflash controller between two requesters
module uflash_arbiter
    import uflash_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2700000,
    parameter int ADDR_W         = 15
) (
    input  logic              clk,
    input  logic              rst_i,
    input  logic              m0_valid,
    input  logic [3:0]        m0_wstrb,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    output logic              m0_ack,
    output logic              m0_done,
    output logic              m0_err,
    output logic [31:0]       m0_rdata,
    input  logic              m1_valid,
    input  logic [3:0]        m1_wstrb,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic              m1_ack,
    output logic              m1_done,
    output logic              m1_err,
    output logic [31:0]       m1_rdata,
    output logic              fl_sel,
    output logic [3:0]        fl_wstrb,
    output logic [ADDR_W-1:0] fl_addr,
    output logic [31:0]       fl_wdata,
    input  logic              fl_ready,
    input  logic [31:0]       fl_rdata,
    output logic              err_timeout,
    output logic              busy
);

    localparam int              CNT_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(TIMEOUT_CYCLES - 2);

    state_t              r_state;
    logic                r_port;
    logic                r_last;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_fl_sel;
    logic [3:0]          r_fl_wstrb;
    logic [ADDR_W-1:0]   r_fl_addr;
    logic [31:0]         r_fl_wdata;
    logic [1:0]          r_done;
    logic [1:0]          r_err;
    logic [31:0]         r_rdata0;
    logic [31:0]         r_rdata1;
    logic                r_err_timeout;

    logic [1:0]          w_grant;
    logic                w_take;
    logic                w_timeout;

    uflash_rr2 u_rr2 (
        .i_req   ({m1_valid, m0_valid}),
        .i_last  (r_last),
        .o_grant (w_grant)
    );

    // A grant needs an idle FSM and an idle controller; a timed-out operation may still be running.
    assign w_take    = (r_state == S_IDLE) && fl_ready && (m0_valid || m1_valid);
    // Counter reaches TIMEOUT_CYCLES-1 on this edge, so the error done lands TIMEOUT_CYCLES after ISSUE.
    assign w_timeout = (r_cnt == CNT_PRE);

    assign m0_ack      = w_take && w_grant[0];
    assign m1_ack      = w_take && w_grant[1];
    assign m0_done     = r_done[0];
    assign m1_done     = r_done[1];
    assign m0_err      = r_err[0];
    assign m1_err      = r_err[1];
    assign m0_rdata    = r_rdata0;
    assign m1_rdata    = r_rdata1;
    assign fl_sel      = r_fl_sel;
    assign fl_wstrb    = r_fl_wstrb;
    assign fl_addr     = r_fl_addr;
    assign fl_wdata    = r_fl_wdata;
    assign err_timeout = r_err_timeout;
    assign busy        = (r_state != S_IDLE);

    // Arbitration FSM: grant, one-cycle select, ready low/high handshake, watchdog.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= S_IDLE;
            r_port        <= 1'b0;
            r_last        <= 1'b1;
            r_cnt         <= '0;
            r_fl_sel      <= 1'b0;
            r_fl_wstrb    <= '0;
            r_fl_addr     <= '0;
            r_fl_wdata    <= '0;
            r_done        <= 2'b00;
            r_err         <= 2'b00;
            r_rdata0      <= '0;
            r_rdata1      <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            r_fl_sel <= 1'b0;
            r_done   <= 2'b00;
            r_err    <= 2'b00;
            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_port     <= w_grant[1];
                        r_fl_wstrb <= w_grant[1] ? m1_wstrb : m0_wstrb;
                        r_fl_addr  <= w_grant[1] ? m1_addr  : m0_addr;
                        r_fl_wdata <= w_grant[1] ? m1_wdata : m0_wdata;
                        r_fl_sel   <= 1'b1;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT_LOW;
                end
                default: begin
                    if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                    if (r_state == S_WAIT_HIGH && fl_ready) begin
                        r_done[r_port] <= 1'b1;
                        if (r_fl_wstrb == OP_READ) begin
                            if (r_port) begin
                                r_rdata1 <= fl_rdata;
                            end else begin
                                r_rdata0 <= fl_rdata;
                            end
                        end
                        r_last  <= r_port;
                        r_state <= S_IDLE;
                    end else if (w_timeout) begin
                        r_done[r_port] <= 1'b1;
                        r_err[r_port]  <= 1'b1;
                        r_err_timeout  <= 1'b1;
                        r_last         <= r_port;
                        r_state        <= S_IDLE;
                    end else if (r_state == S_WAIT_LOW && !fl_ready) begin
                        r_state <= S_WAIT_HIGH;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uflash_arbiter.sv
// tb/tb_uflash_arbiter.sv - randomized scoreboard bench for uflash_arbiter
module tb_uflash_arbiter;

    localparam int TO = 16;

    typedef struct {
        bit          p;
        bit          err;
        logic [31:0] r0;
        logic [31:0] r1;
    } exp_t;

    typedef struct {
        logic [3:0]  s;
        logic [14:0] a;
        logic [31:0] d;
    } pay_t;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        vld [2];
    logic [3:0]  ws  [2];
    logic [14:0] ad  [2];
    logic [31:0] wd  [2];
    logic        m0_ack, m0_done, m0_err, m1_ack, m1_done, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        fl_sel, fl_ready, err_timeout, busy;
    logic [3:0]  fl_wstrb;
    logic [14:0] fl_addr;
    logic [31:0] fl_wdata, fl_rdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ack_cnt [2];
    int sel_cnt = 0;
    int ack_cyc = 0, sel_cyc = 0, done_cyc = 0;
    bit prev_sel = 0, prev_done = 0;
    bit gseq [$];

    exp_t exp_q [$];
    pay_t pay_q [$];
    logic [31:0] mmem [logic [14:0]];
    logic [31:0] bmem [logic [14:0]];
    logic [31:0] mrd [2];
    bit          mlast = 1'b1;

    int  bfm_lo = 1;
    bit  bfm_hang = 0;
    bit  bfm_rand = 0;

    always #5 clk = ~clk;

    uflash_arbiter #(.TIMEOUT_CYCLES(TO), .ADDR_W(15)) dut (
        .clk(clk), .rst_i(rst_i),
        .m0_valid(vld[0]), .m0_wstrb(ws[0]), .m0_addr(ad[0]), .m0_wdata(wd[0]),
        .m0_ack(m0_ack), .m0_done(m0_done), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_valid(vld[1]), .m1_wstrb(ws[1]), .m1_addr(ad[1]), .m1_wdata(wd[1]),
        .m1_ack(m1_ack), .m1_done(m1_done), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .fl_sel(fl_sel), .fl_wstrb(fl_wstrb), .fl_addr(fl_addr), .fl_wdata(fl_wdata),
        .fl_ready(fl_ready), .fl_rdata(fl_rdata),
        .err_timeout(err_timeout), .busy(busy)
    );

    function automatic logic [31:0] mdef(input logic [14:0] a);
        return 32'hA500_0000 ^ {17'd0, a};
    endfunction

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Controller model: ready falls the cycle after sel, stays low bfm_lo cycles (or while hung).
    initial begin
        logic [3:0]  bs;
        logic [14:0] ba;
        logic [31:0] bd;
        int          lo;
        fl_ready = 1'b1;
        fl_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (fl_sel) begin
                bs = fl_wstrb; ba = fl_addr; bd = fl_wdata;
                lo = bfm_rand ? int'($urandom_range(1, 4)) : bfm_lo;
                @(posedge clk); #1;
                fl_ready = 1'b0;
                repeat (lo) @(posedge clk);
                while (bfm_hang) @(posedge clk);
                #1;
                if (bs == 4'b0000) fl_rdata = bmem.exists(ba) ? bmem[ba] : mdef(ba);
                else fl_rdata = $urandom;
                if (bs == 4'b1111) bmem[ba] = bd;
                else if (bs == 4'b0001) bmem[ba] = 32'hFFFF_FFFF;
                fl_ready = 1'b1;
            end
        end
    end

    // Monitor: predicts grants and results from the operation semantics, checks every DUT event.
    always @(negedge clk) begin
        bit   p, ep, e;
        exp_t x;
        pay_t y;
        cyc++;
        if (rst_i) begin
            prev_sel = 0;
            prev_done = 0;
        end else begin
            if (m0_ack || m1_ack) begin
                p = m1_ack;
                chk(!(m0_ack && m1_ack), "ack_onehot", 64'({m1_ack, m0_ack}), 64'd1);
                chk(fl_ready === 1'b1, "ack_ready", 64'(fl_ready), 64'd1);
                ep = (vld[0] && vld[1]) ? !mlast : vld[1];
                chk(p == ep, "grant_order", 64'(p), 64'(ep));
                mlast = p;
                gseq.push_back(p);
                e = bfm_hang;
                if (!e) begin
                    if (ws[p] == 4'b0000) mrd[p] = mmem.exists(ad[p]) ? mmem[ad[p]] : mdef(ad[p]);
                    else if (ws[p] == 4'b1111) mmem[ad[p]] = wd[p];
                    else if (ws[p] == 4'b0001) mmem[ad[p]] = 32'hFFFF_FFFF;
                end
                exp_q.push_back('{p: p, err: e, r0: mrd[0], r1: mrd[1]});
                pay_q.push_back('{s: ws[p], a: ad[p], d: wd[p]});
                ack_cnt[p]++;
                ack_cyc = cyc;
            end
            if (fl_sel) begin
                chk(!prev_sel, "sel_single", 64'(prev_sel), 64'd0);
                chk(pay_q.size() > 0, "sel_expected", 64'(pay_q.size()), 64'd1);
                if (pay_q.size() > 0) begin
                    y = pay_q.pop_front();
                    chk({fl_wstrb, fl_addr, fl_wdata} == {y.s, y.a, y.d}, "sel_payload",
                        64'({fl_wstrb, fl_addr, fl_wdata}), 64'({y.s, y.a, y.d}));
                end
                sel_cnt++;
                sel_cyc = cyc;
            end
            if (m0_done || m1_done) begin
                chk(!(m0_done && m1_done), "done_onehot", 64'({m1_done, m0_done}), 64'd1);
                chk(!prev_done, "done_single", 64'(prev_done), 64'd0);
                chk(exp_q.size() > 0, "done_expected", 64'(exp_q.size()), 64'd1);
                if (exp_q.size() > 0) begin
                    x = exp_q.pop_front();
                    chk(m1_done == x.p, "done_port", 64'(m1_done), 64'(x.p));
                    chk((x.p ? m1_err : m0_err) == x.err, "done_err", 64'({m1_err, m0_err}), 64'(x.err));
                    chk(m0_rdata == x.r0, "m0_rdata", 64'(m0_rdata), 64'(x.r0));
                    chk(m1_rdata == x.r1, "m1_rdata", 64'(m1_rdata), 64'(x.r1));
                    if (x.err) chk(err_timeout, "err_timeout_set", 64'(err_timeout), 64'd1);
                end
                done_cyc = cyc;
            end
            prev_sel = fl_sel;
            prev_done = m0_done || m1_done;
        end
    end

    task automatic issue(input int p, input logic [3:0] s, input logic [14:0] a, input logic [31:0] d);
        int n;
        @(posedge clk); #1;
        ws[p] = s; ad[p] = a; wd[p] = d; vld[p] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(p == 1 ? m1_ack : m0_ack) && n < 400);
        if (n >= 400) chk(0, "ack_wait", 64'(n), 64'd0);
        @(posedge clk); #1;
        vld[p] = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_q.size() != 0 || busy) && n < 400);
        if (n >= 400) chk(0, "idle_wait", 64'(n), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic rand_port(input int p, input int n);
        logic [3:0] ops [5];
        ops[0] = 4'b0000; ops[1] = 4'b1111; ops[2] = 4'b0001; ops[3] = 4'b0000; ops[4] = 4'b0101;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            issue(p, ops[$urandom_range(0, 4)], 15'($urandom_range(0, 7)), $urandom);
        end
    endtask

    initial begin
        int a0, s0;
        bit alt;
        #200_000;
        $display("FAIL global_timeout actual=%0d required=0", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        int a0, s0;
        bit alt;
        vld[0] = 0; vld[1] = 0;
        ws[0] = 0; ws[1] = 0; ad[0] = 0; ad[1] = 0; wd[0] = 0; wd[1] = 0;
        ack_cnt[0] = 0; ack_cnt[1] = 0;
        mrd[0] = 0; mrd[1] = 0;
        bmem[15'h040] = 32'h1234_5678;
        mmem[15'h040] = 32'h1234_5678;
        repeat (3) @(posedge clk); #1;
        chk({busy, fl_sel, fl_wstrb, fl_addr, fl_wdata, m0_done, m1_done, m0_err, m1_err,
             err_timeout, m0_ack, m1_ack} == '0, "reset_outputs", 64'(fl_wdata), 64'd0);
        chk({m0_rdata, m1_rdata} == 64'd0, "reset_rdata", {m0_rdata, m1_rdata}, 64'd0);
        rst_i = 1'b0;

        // Port 0 write, ready low for 5 cycles.
        bfm_lo = 5; a0 = ack_cnt[0]; s0 = sel_cnt;
        issue(0, 4'b1111, 15'h000, 32'hC001_CAFE);
        wait_idle();
        chk(ack_cnt[0] - a0 == 1, "t1_acks", 64'(ack_cnt[0] - a0), 64'd1);
        chk(sel_cnt - s0 == 1, "t1_sels", 64'(sel_cnt - s0), 64'd1);
        chk(fl_wdata == 32'hC001_CAFE, "t1_wdata_hold", 64'(fl_wdata), 64'hC001_CAFE);
        chk(done_cyc - sel_cyc == 7, "t1_latency", 64'(done_cyc - sel_cyc), 64'd7);

        // Port 1 read of 0x040.
        bfm_lo = 2;
        issue(1, 4'b0000, 15'h040, 32'h0);
        wait_idle();
        chk(m1_rdata == 32'h1234_5678, "t2_m1_rdata", 64'(m1_rdata), 64'h1234_5678);
        chk(m0_rdata == 32'h0, "t2_m0_rdata", 64'(m0_rdata), 64'h0);

        // Port 0 erase at minimum timing, then read back.
        bfm_lo = 1;
        issue(0, 4'b0001, 15'h040, 32'hDEAD_BEEF);
        wait_idle();
        chk(done_cyc - ack_cyc == 4, "erase_latency", 64'(done_cyc - ack_cyc), 64'd4);
        chk(m0_rdata == 32'h0, "erase_rdata", 64'(m0_rdata), 64'h0);
        issue(0, 4'b0000, 15'h040, 32'h0);
        wait_idle();
        chk(m0_rdata == 32'hFFFF_FFFF, "erase_readback", 64'(m0_rdata), 64'hFFFF_FFFF);

        // Both ports busy, 6 ops each: grants must alternate.
        bfm_lo = 3; s0 = sel_cnt; gseq.delete();
        fork
            for (int i = 0; i < 6; i++) issue(0, 4'b1111, 15'(8 + i), $urandom);
            for (int i = 0; i < 6; i++) issue(1, 4'b0000, 15'(8 + i), 32'h0);
        join
        wait_idle();
        chk(sel_cnt - s0 == 12, "alt_sels", 64'(sel_cnt - s0), 64'd12);
        alt = (gseq.size() == 12);
        for (int i = 1; i < gseq.size(); i++) if (gseq[i] == gseq[i-1]) alt = 0;
        chk(alt, "alt_pattern", 64'(gseq.size()), 64'd12);

        // Watchdog: controller never raises ready.
        bfm_hang = 1;
        issue(0, 4'b0000, 15'h011, 32'h0);
        wait_idle();
        chk(done_cyc - sel_cyc == TO, "timeout_cycles", 64'(done_cyc - sel_cyc), 64'(TO));
        chk(err_timeout == 1'b1, "timeout_sticky", 64'(err_timeout), 64'd1);
        a0 = ack_cnt[1];
        fork
            issue(1, 4'b0000, 15'h040, 32'h0);
            begin
                repeat (6) @(negedge clk);
                chk(ack_cnt[1] == a0, "timeout_no_grant", 64'(ack_cnt[1] - a0), 64'd0);
                bfm_hang = 0;
            end
        join
        wait_idle();
        chk(err_timeout == 1'b1, "timeout_still_set", 64'(err_timeout), 64'd1);

        // Reset while waiting for ready high.
        bfm_hang = 1;
        issue(0, 4'b0000, 15'h010, 32'h0);
        repeat (3) @(posedge clk); #3;
        chk(busy == 1'b1, "busy_before_reset", 64'(busy), 64'd1);
        rst_i = 1'b1; #1;
        chk({busy, fl_sel, fl_wstrb, fl_addr, fl_wdata, m0_done, m1_done, m0_err, m1_err,
             err_timeout} == '0, "async_reset_outputs", 64'({busy, fl_sel, err_timeout}), 64'd0);
        chk({m0_rdata, m1_rdata} == 64'd0, "async_reset_rdata", {m0_rdata, m1_rdata}, 64'd0);
        exp_q.delete(); pay_q.delete();
        mlast = 1'b1; mrd[0] = 0; mrd[1] = 0;
        @(posedge clk); #3;
        rst_i = 1'b0;
        a0 = ack_cnt[0];
        fork
            issue(0, 4'b1111, 15'h012, 32'h5555_AAAA);
            begin
                repeat (6) @(negedge clk);
                chk(ack_cnt[0] == a0, "reset_no_grant", 64'(ack_cnt[0] - a0), 64'd0);
                bfm_hang = 0;
            end
        join
        wait_idle();

        // Randomized traffic on both ports.
        bfm_rand = 1;
        fork
            rand_port(0, 20);
            rand_port(1, 20);
        join
        wait_idle();
        chk(sel_cnt == ack_cnt[0] + ack_cnt[1], "sel_vs_ack", 64'(sel_cnt), 64'(ack_cnt[0] + ack_cnt[1]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
